// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_pkg
//  Description : Shared AXI write-path encodings (burst types, response
//                codes) and the slave write FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_pkg;

    // AxBURST encodings
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // xRESP encodings
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Slave write-path FSM
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_W_DATA = 2'd1,
        S_W_RESP = 2'd2
    } wr_state_t;

    // The slave only implements FIXED and INCR; WRAP and the reserved code
    // are terminated with an error response.
    function automatic logic burst_unsupported(input logic [1:0] i_burst);
        return (i_burst == BURST_WRAP) || (i_burst == 2'b11);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_slave_wr_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_slave_wr_if
//  Description : AW/W/B channel bundle plus the test read-back port of the
//                AXI write slave. master = traffic source, slave = terminator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_slave_wr_if #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 8,
    parameter int SIZE_BITS = 3,
    parameter int IDX_BITS  = 4
);
    // Write address channel
    logic                   aw_valid;
    logic                   aw_ready;
    logic [ADDR_BITS-1:0]   aw_addr;
    logic [LEN_BITS-1:0]    aw_len;
    logic [SIZE_BITS-1:0]   aw_size;
    logic [1:0]             aw_burst;
    logic [3:0]             aw_cache;

    // Write data channel
    logic                   w_valid;
    logic                   w_ready;
    logic [DATA_BITS-1:0]   w_data;
    logic [DATA_BITS/8-1:0] w_strb;
    logic                   w_last;

    // Write response channel
    logic                   b_valid;
    logic                   b_ready;
    logic [1:0]             b_resp;

    // Test read-back port
    logic [IDX_BITS-1:0]    rd_addr;
    logic [DATA_BITS-1:0]   rd_data;

    modport slave (
        input  aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_cache,
        input  w_valid, w_data, w_strb, w_last,
        input  b_ready,
        input  rd_addr,
        output aw_ready, w_ready, b_valid, b_resp, rd_data
    );

    modport master (
        output aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_cache,
        output w_valid, w_data, w_strb, w_last,
        output b_ready,
        output rd_addr,
        input  aw_ready, w_ready, b_valid, b_resp, rd_data
    );

endinterface
`default_nettype wire

// File: rtl/axi_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module      : axi_slave_mem
//  Description : MEM_DEPTH x DATA_BITS byte-enabled register array with
//                asynchronous active-low reset, one write port and one
//                registered read port (read-during-write returns old data).
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_slave_mem #(
    parameter int DATA_BITS = 32,
    parameter int MEM_DEPTH = 16,
    parameter int IDX_BITS  = $clog2(MEM_DEPTH)
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   i_wr_en,
    input  wire logic [IDX_BITS-1:0]    i_wr_idx,
    input  wire logic [DATA_BITS-1:0]   i_wr_data,
    input  wire logic [DATA_BITS/8-1:0] i_wr_strb,
    input  wire logic [IDX_BITS-1:0]    i_rd_idx,
    output logic      [DATA_BITS-1:0]   o_rd_data
);

    localparam int C_BYTES = DATA_BITS / 8;

    logic [DATA_BITS-1:0] r_mem [MEM_DEPTH];
    logic [DATA_BITS-1:0] r_rd_data;

    // Byte-lane writes into the addressed word; whole array clears on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < MEM_DEPTH; w++) begin
                r_mem[w] <= '0;
            end
        end else if (i_wr_en) begin
            for (int b = 0; b < C_BYTES; b++) begin
                if (i_wr_strb[b]) begin
                    r_mem[i_wr_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
                end
            end
        end
    end

    // Registered read: samples the array before any same-edge write lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[i_rd_idx];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/axi_slave_wr.sv
`default_nettype none
// ============================================================================
//  Module      : axi_slave_wr
//  Description : AXI write-channel slave. Accepts one AW phase, then
//                aw_len+1 W beats written into a word-addressed register
//                memory under w_strb, then one B response. Only one burst
//                is in flight at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_slave_wr
    import axi_pkg::*;
#(
    parameter int                   ADDR_BITS = 32,
    parameter int                   DATA_BITS = 32,
    parameter int                   LEN_BITS  = 8,
    parameter int                   SIZE_BITS = 3,
    parameter int                   MEM_DEPTH = 16,
    parameter logic [ADDR_BITS-1:0] BASE_ADDR = '0
) (
    input  wire logic     aclk,
    input  wire logic     areset_n,
    axi_slave_wr_if.slave bus
);

    localparam int                   C_BYTES    = DATA_BITS / 8;
    localparam int                   C_SHIFT    = $clog2(C_BYTES);
    localparam int                   C_IDX_BITS = $clog2(MEM_DEPTH);
    localparam logic [SIZE_BITS-1:0] C_MAX_SIZE = SIZE_BITS'(C_SHIFT);
    localparam logic [ADDR_BITS-1:0] C_DEPTH    = ADDR_BITS'(MEM_DEPTH);

    wr_state_t r_state;
    wr_state_t w_next_state;

    // Burst context; the address is kept as a byte offset from BASE_ADDR
    logic [ADDR_BITS-1:0]  r_cur_off;
    logic [LEN_BITS-1:0]   r_len;
    logic [SIZE_BITS-1:0]  r_size;
    logic [1:0]            r_burst;
    logic [LEN_BITS-1:0]   r_cnt;
    logic                  r_err;

    logic [ADDR_BITS-1:0]  w_start_off;
    logic                  w_start_err;
    logic [ADDR_BITS-1:0]  w_cur_word;
    logic                  w_in_range;
    logic                  w_aw_hs;
    logic                  w_beat;
    logic                  w_final;
    logic                  w_last_bad;
    logic                  w_wr_en;
    logic [C_IDX_BITS-1:0] w_wr_idx;
    logic [ADDR_BITS-1:0]  w_step;
    logic                  w_unused_cache;

    // Cache attributes carry no meaning for a register memory
    assign w_unused_cache = ^bus.aw_cache;

    // Start-of-burst decode: offset into the memory and the up-front errors
    assign w_start_off = bus.aw_addr - BASE_ADDR;
    assign w_start_err = burst_unsupported(bus.aw_burst)
                       || (bus.aw_size > C_MAX_SIZE)
                       || ((w_start_off >> C_SHIFT) >= C_DEPTH);

    // Per-beat decode. The full-width word index is compared against the
    // depth so an INCR run past the top is caught instead of wrapping.
    assign w_cur_word = r_cur_off >> C_SHIFT;
    assign w_in_range = (w_cur_word < C_DEPTH);
    assign w_aw_hs    = (r_state == S_IDLE) && bus.aw_valid;
    assign w_beat     = (r_state == S_W_DATA) && bus.w_valid;
    assign w_final    = (r_cnt == r_len);
    assign w_last_bad = (bus.w_last != w_final);
    assign w_wr_en    = w_beat && !r_err && w_in_range;
    assign w_wr_idx   = w_cur_word[C_IDX_BITS-1:0];
    assign w_step     = ADDR_BITS'(1) << r_size;

    // Channel outputs follow directly from the registered state
    assign bus.aw_ready = (r_state == S_IDLE);
    assign bus.w_ready  = (r_state == S_W_DATA);
    assign bus.b_valid  = (r_state == S_W_RESP);
    assign bus.b_resp   = ((r_state == S_W_RESP) && r_err) ? RESP_SLVERR : RESP_OKAY;

    // FSM state register
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state: burst ends on the beat count, never on w_last
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.aw_valid) begin
                    w_next_state = S_W_DATA;
                end
            end
            S_W_DATA: begin
                if (bus.w_valid && w_final) begin
                    w_next_state = S_W_RESP;
                end
            end
            S_W_RESP: begin
                if (bus.b_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Burst context, beat counter, address advance and error tracking
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_cur_off <= '0;
            r_len     <= '0;
            r_size    <= '0;
            r_burst   <= BURST_FIXED;
            r_cnt     <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_cur_off <= w_start_off;
                r_len     <= bus.aw_len;
                r_size    <= bus.aw_size;
                r_burst   <= bus.aw_burst;
                r_cnt     <= '0;
                r_err     <= w_start_err;
            end else if (w_beat) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_burst == BURST_INCR) begin
                    r_cur_off <= r_cur_off + w_step;
                end
                if (!w_in_range || w_last_bad) begin
                    r_err <= 1'b1;
                end
            end else if ((r_state == S_W_RESP) && bus.b_ready) begin
                r_err <= 1'b0;
            end
        end
    end

    axi_slave_mem #(
        .DATA_BITS (DATA_BITS),
        .MEM_DEPTH (MEM_DEPTH),
        .IDX_BITS  (C_IDX_BITS)
    ) u_mem (
        .clk       (aclk),
        .rst_n     (areset_n),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (w_wr_idx),
        .i_wr_data (bus.w_data),
        .i_wr_strb (bus.w_strb),
        .i_rd_idx  (bus.rd_addr),
        .o_rd_data (bus.rd_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_axi_slave_wr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_slave_wr
//  Description : Self-checking bench for axi_slave_wr: directed scenarios
//                plus randomized bursts against a behavioural memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_slave_wr;

    logic clk;
    logic rst_n;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] mem_model [16];
    logic [31:0] beat_data [16];
    logic [3:0]  beat_strb [16];
    bit          beat_last [16];

    axi_slave_wr_if #(
        .ADDR_BITS (32), .DATA_BITS (32), .LEN_BITS (8), .SIZE_BITS (3), .IDX_BITS (4)
    ) bus ();

    axi_slave_wr #(
        .ADDR_BITS (32), .DATA_BITS (32), .LEN_BITS (8), .SIZE_BITS (3),
        .MEM_DEPTH (16), .BASE_ADDR (32'h0)
    ) u_dut (
        .aclk     (clk),
        .areset_n (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Spec-level burst semantics: decide the response and apply the writes.
    task automatic model_apply(input logic [31:0] addr, input int len, input int size,
                               input int burst, output logic [1:0] resp);
        bit          err;
        logic [31:0] a;
        logic [31:0] idx;
        err = (burst >= 2) || (size > 2) || ((addr >> 2) >= 32'd16);
        a = addr;
        for (int b = 0; b <= len; b++) begin
            idx = a >> 2;
            if (!err && idx < 32'd16) begin
                for (int k = 0; k < 4; k++) begin
                    if (beat_strb[b][k]) mem_model[idx[3:0]][k*8 +: 8] = beat_data[b][k*8 +: 8];
                end
            end
            if (idx >= 32'd16) err = 1'b1;
            if (beat_last[b] != (b == len)) err = 1'b1;
            if (burst == 1) a = a + (32'd1 << size);
        end
        resp = err ? 2'b10 : 2'b00;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mem_model[i] = 32'h0;
    endtask

    task automatic set_beats_default(input int len);
        for (int b = 0; b < 16; b++) begin
            beat_strb[b] = 4'hF;
            beat_last[b] = (b == len);
        end
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 16; i++) begin
            bus.rd_addr = 4'(i);
            @(posedge clk); #1;
            checks++;
            if (bus.rd_data !== mem_model[i]) begin
                errors++;
                $display("FAIL %s mem[%0d]: got %h expected %h", tag, i, bus.rd_data, mem_model[i]);
            end
        end
    endtask

    // Drive one complete AW/W/B transaction and check channel behaviour.
    task automatic run_burst(input logic [31:0] addr, input int len, input int size,
                             input int burst, input int hold_b, input bit early_b,
                             input int gap_max, input string tag,
                             output logic [31:0] rd_after, output logic [31:0] rd_next);
        logic [1:0] exp_resp;
        model_apply(addr, len, size, burst, exp_resp);

        bus.aw_addr  = addr;
        bus.aw_len   = 8'(len);
        bus.aw_size  = 3'(size);
        bus.aw_burst = 2'(burst);
        bus.aw_cache = 4'($urandom);
        bus.aw_valid = 1'b1;
        checks++;
        if (bus.aw_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s aw_ready_idle: got %b expected 1", tag, bus.aw_ready);
        end
        @(posedge clk); #1;
        bus.aw_valid = 1'($urandom_range(0, 1));   // stray AW must be ignored
        checks++;
        if (bus.w_ready !== 1'b1 || bus.aw_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s w_ready_after_aw: got w_ready=%b aw_ready=%b expected 1/0",
                     tag, bus.w_ready, bus.aw_ready);
        end
        if (early_b) bus.b_ready = 1'b1;

        for (int b = 0; b <= len; b++) begin
            int gaps;
            gaps = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            repeat (gaps) begin
                bus.w_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus.w_valid = 1'b1;
            bus.w_data  = beat_data[b];
            bus.w_strb  = beat_strb[b];
            bus.w_last  = beat_last[b];
            @(posedge clk); #1;
        end
        bus.w_valid  = 1'b0;
        bus.w_last   = 1'b0;
        bus.aw_valid = 1'b0;
        rd_after = bus.rd_data;
        rd_next  = 32'hx;

        checks++;
        if (bus.b_valid !== 1'b1 || bus.b_resp !== exp_resp || bus.w_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s b_after_last: got b_valid=%b b_resp=%b w_ready=%b expected 1/%b/0",
                     tag, bus.b_valid, bus.b_resp, bus.w_ready, exp_resp);
        end

        if (early_b) begin
            @(posedge clk); #1;
            rd_next = bus.rd_data;
            bus.b_ready = 1'b0;
        end else begin
            for (int i = 0; i < hold_b; i++) begin
                @(posedge clk); #1;
                if (i == 0) rd_next = bus.rd_data;
                checks++;
                if (bus.b_valid !== 1'b1 || bus.b_resp !== exp_resp) begin
                    errors++;
                    $display("FAIL %s b_hold%0d: got b_valid=%b b_resp=%b expected 1/%b",
                             tag, i, bus.b_valid, bus.b_resp, exp_resp);
                end
            end
            bus.b_ready = 1'b1;
            @(posedge clk); #1;
            if (hold_b == 0) rd_next = bus.rd_data;
            bus.b_ready = 1'b0;
        end
        checks++;
        if (bus.b_valid !== 1'b0 || bus.aw_ready !== 1'b1 || bus.b_resp !== 2'b00) begin
            errors++;
            $display("FAIL %s after_b_hs: got b_valid=%b aw_ready=%b b_resp=%b expected 0/1/00",
                     tag, bus.b_valid, bus.aw_ready, bus.b_resp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.aw_ready !== 1'b1 || bus.w_ready !== 1'b0 || bus.b_valid !== 1'b0 ||
            bus.b_resp !== 2'b00 || bus.rd_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got aw_ready=%b w_ready=%b b_valid=%b b_resp=%b rd_data=%h expected 1/0/0/00/0",
                     bus.aw_ready, bus.w_ready, bus.b_valid, bus.b_resp, bus.rd_data);
        end
        rst_n = 1'b1;
        model_clear();
        check_mem("reset");
    endtask

    task automatic test_single();
        logic [31:0] ra, rn;
        set_beats_default(0);
        beat_data[0] = 32'hDEADBEEF;
        bus.rd_addr = 4'd2;
        run_burst(32'h8, 0, 2, 1, 0, 1'b0, 0, "single", ra, rn);
        checks++;
        if (ra !== 32'h0) begin
            errors++;
            $display("FAIL single_rd_same_edge: got %h expected 00000000", ra);
        end
        checks++;
        if (rn !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_rd_next: got %h expected deadbeef", rn);
        end
    endtask

    task automatic test_incr4();
        logic [31:0] ra, rn;
        set_beats_default(3);
        beat_data[0] = 32'h11; beat_data[1] = 32'h22;
        beat_data[2] = 32'h33; beat_data[3] = 32'h44;
        run_burst(32'h0, 3, 2, 1, 0, 1'b0, 3, "incr4", ra, rn);
        check_mem("incr4");
    endtask

    task automatic test_fixed3();
        logic [31:0] ra, rn;
        set_beats_default(2);
        beat_data[0] = 32'hA; beat_data[1] = 32'hB; beat_data[2] = 32'hC;
        beat_strb[2] = 4'h1;
        run_burst(32'h4, 2, 2, 0, 0, 1'b0, 0, "fixed3", ra, rn);
        checks++;
        if (mem_model[1] !== 32'h0000000C) begin
            errors++;
            $display("FAIL fixed3_model_word1: got %h expected 0000000c", mem_model[1]);
        end
        check_mem("fixed3");
    endtask

    task automatic test_errors();
        logic [31:0] ra, rn;
        set_beats_default(1);
        beat_data[0] = 32'hCAFE0001; beat_data[1] = 32'hCAFE0002;
        run_burst(32'h10, 1, 2, 2, 0, 1'b0, 0, "err_wrap", ra, rn);
        set_beats_default(0);
        beat_data[0] = 32'hBAD0BAD0;
        run_burst(32'h40, 0, 2, 1, 0, 1'b0, 0, "err_range", ra, rn);
        set_beats_default(3);
        for (int b = 0; b < 4; b++) beat_data[b] = 32'h5500_0000 + 32'(b);
        run_burst(32'h38, 3, 2, 1, 0, 1'b0, 1, "err_overrun", ra, rn);
        check_mem("errors");
    endtask

    task automatic test_wlast();
        logic [31:0] ra, rn;
        set_beats_default(2);
        beat_last[1] = 1'b1;
        beat_data[0] = 32'h77770000; beat_data[1] = 32'h77771111; beat_data[2] = 32'h77772222;
        run_burst(32'h20, 2, 2, 1, 0, 1'b0, 0, "wlast", ra, rn);
        check_mem("wlast");
    endtask

    task automatic test_back_pressure();
        logic [31:0] ra, rn;
        set_beats_default(0);
        beat_data[0] = 32'h0BADF00D;
        run_burst(32'h28, 0, 2, 1, 5, 1'b0, 0, "b_hold", ra, rn);
        beat_data[0] = 32'h600DF00D;
        run_burst(32'h2C, 0, 2, 1, 0, 1'b1, 0, "b_early", ra, rn);
        check_mem("back_pressure");
    endtask

    task automatic test_random();
        logic [31:0] ra, rn;
        for (int n = 0; n < 40; n++) begin
            logic [31:0] addr;
            int len, size, burst, sel;
            len  = $urandom_range(0, 5);
            addr = 32'($urandom_range(0, 19)) << 2;
            if ($urandom_range(0, 4) == 0) addr = addr | 32'($urandom_range(0, 3));
            size = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            sel  = $urandom_range(0, 9);
            burst = (sel < 5) ? 1 : (sel < 8) ? 0 : (sel == 8) ? 2 : 3;
            set_beats_default(len);
            for (int b = 0; b <= len; b++) begin
                beat_data[b] = $urandom;
                beat_strb[b] = 4'($urandom);
            end
            if ($urandom_range(0, 9) == 0) begin
                int fb;
                fb = $urandom_range(0, len);
                beat_last[fb] = !beat_last[fb];
            end
            run_burst(addr, len, size, burst, $urandom_range(0, 3),
                      1'($urandom_range(0, 3) == 0), 2, "random", ra, rn);
            if (n % 8 == 7) check_mem("random");
        end
    endtask

    task automatic test_reset_mid();
        bus.aw_addr = 32'h0; bus.aw_len = 8'd3; bus.aw_size = 3'd2;
        bus.aw_burst = 2'b01; bus.aw_valid = 1'b1;
        @(posedge clk); #1;
        bus.aw_valid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bus.w_valid = 1'b1; bus.w_data = 32'hF00D0000 + 32'(b);
            bus.w_strb = 4'hF; bus.w_last = 1'b0;
            @(posedge clk); #1;
        end
        bus.w_valid = 1'b0;
        checks++;
        if (bus.w_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_in_data: got w_ready=%b expected 1", bus.w_ready);
        end
        bus.rd_addr = 4'd0;
        @(posedge clk); #1;
        checks++;
        if (bus.rd_data !== 32'hF00D0000) begin
            errors++;
            $display("FAIL reset_mid_partial_write: got %h expected f00d0000", bus.rd_data);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.aw_ready !== 1'b1 || bus.w_ready !== 1'b0 || bus.b_valid !== 1'b0 ||
            bus.b_resp !== 2'b00 || bus.rd_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got aw_ready=%b w_ready=%b b_valid=%b b_resp=%b rd_data=%h expected 1/0/0/00/0",
                     bus.aw_ready, bus.w_ready, bus.b_valid, bus.b_resp, bus.rd_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_clear();
        check_mem("reset_mid");
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.aw_valid = 1'b0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_size = '0;
        bus.aw_burst = '0;   bus.aw_cache = '0;
        bus.w_valid  = 1'b0; bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0;
        bus.b_ready  = 1'b0; bus.rd_addr = '0;

        test_reset();
        test_single();
        test_incr4();
        test_fixed3();
        test_errors();
        test_wlast();
        test_back_pressure();
        test_random();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_slave_wr.md
Name: axi_slave_wr

Overview:
AXI write-channel slave that terminates the AW/W/B traffic produced by the team's AXI master write interface. It accepts one address phase and then aw_len+1 data beats, and writes each beat into an internal word-addressed register memory under w_strb. It returns one write response per burst. A registered test read-back port lets the bench check memory contents.

Parameters:
ADDR_BITS, `ADDR_BITS (32): address width.
DATA_BITS, `DATA_BITS (32): data width; must be a power of 2, at least 8.
LEN_BITS, `LEN_BITS (8): burst length field width.
SIZE_BITS, `SIZE_BITS (3): burst size field width.
MEM_DEPTH, 16: number of DATA_BITS-wide words; must be a power of 2.
BASE_ADDR, 0: byte address of word 0.

Ports:
aclk  in  1  clock, rising edge.
areset_n  in  1  asynchronous active-low reset.
aw_valid  in  1  write address valid.
aw_ready  out  1  write address ready.
aw_addr  in  ADDR_BITS  start byte address.
aw_len  in  LEN_BITS  beats-1.
aw_size  in  SIZE_BITS  log2 bytes per beat.
aw_burst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
aw_cache  in  4  accepted, ignored.
w_valid  in  1  write data valid.
w_ready  out  1  write data ready.
w_data  in  DATA_BITS  write data.
w_strb  in  DATA_BITS/8  byte enables.
w_last  in  1  last beat marker.
b_valid  out  1  response valid.
b_ready  in  1  response ready.
b_resp  out  2  00 OKAY, 10 SLVERR.
rd_addr  in  log2(MEM_DEPTH)  test read word index.
rd_data  out  DATA_BITS  word at rd_addr, 1-cycle registered latency.

Behaviour:
- Reset (async, areset_n=0): state=IDLE; aw_ready=1; w_ready=0; b_valid=0; b_resp=00; rd_data=0; beat counter=0; error flag=0; all memory words=0.
- FSM IDLE -> W_DATA -> W_RESP -> IDLE. Only one burst is outstanding at a time.
- IDLE:
  - aw_ready=1.
  - On aw_valid&&aw_ready: latch addr, len, size, burst; clear beat counter; w_ready<=1; aw_ready<=0; go to W_DATA.
  - The error flag is preset on entry to W_DATA if any of these holds: burst is WRAP or reserved; aw_size > log2(DATA_BITS/8); start word index (aw_addr-BASE_ADDR)>>log2(DATA_BITS/8) >= MEM_DEPTH.
- W_DATA:
  - w_ready=1. A beat transfers on w_valid&&w_ready, i.e. zero-wait acceptance.
  - If the error flag is clear, each byte i with w_strb[i]=1 is written into mem[cur_word], in the same edge.
  - FIXED: cur address stays constant.
  - INCR: cur address += (1<<size) bytes after each beat.
  - If INCR crosses past MEM_DEPTH-1, the beat is not written and the error flag is set. The index must not wrap.
  - Beat counter increments per beat.
  - Final beat is counter==len. On it: w_ready<=0, b_valid<=1, go to W_RESP.
  - w_last check: if w_last disagrees with (counter==len) on any beat, the error flag is set. Termination is still by count only.
  - w_valid low: hold, no state change.
- W_RESP:
  - b_valid=1; b_resp = error flag ? 10 : 00. Both are stable until b_ready.
  - On b_valid&&b_ready: b_valid<=0, clear the error flag, aw_ready<=1, go to IDLE.
  - b_ready asserted early (before b_valid) is legal. Response completes in the first W_RESP cycle.
- Latency:
  - AW handshake to w_ready: 1 cycle.
  - Final beat to b_valid: 1 cycle.
  - b handshake to aw_ready: 1 cycle.
- Read port: rd_data <= mem[rd_addr] every cycle. Same-edge write to the same word returns the old data; new data appears one cycle later.
- Reset mid-burst: abort immediately to reset values. The partial burst's prior writes are discarded because the memory is reset.
- aw_valid during W_DATA/W_RESP: ignored (aw_ready=0).

Decomposition:
- Shared package axi_pkg holds:
  - Burst encodings BURST_FIXED/INCR/WRAP.
  - Response codes RESP_OKAY/RESP_SLVERR.
  - FSM state enum for the slave write path.
- Widths continue to come from define.sv.
- One sub-module, axi_slave_mem: MEM_DEPTH x DATA_BITS byte-enabled register array with async reset, a write port (en, idx, data, strb) and a registered read port.

Test Plan:
- Single beat: aw_addr=0x8, len=0, INCR, size=2, w_data=0xDEADBEEF, strb=F, w_last=1 -> b_resp=00 one cycle later; rd_addr=2 returns 0xDEADBEEF.
- INCR 4 beats: addr=0x0, len=3, data 0x11,0x22,0x33,0x44 -> words 0..3 hold the data; b_resp=00; w_valid gaps between beats are tolerated.
- FIXED 3 beats: addr=0x4, data 0xA,0xB,0xC, last beat strb=0x1 -> word1=0x0000000C... then final byte write: word1=0x0000000C; b_resp=00.
- Errors:
  - WRAP burst -> b_resp=10, memory unchanged.
  - addr=0x40 (index 16) -> b_resp=10, memory unchanged.
  - INCR len=3 starting at index 14 -> words 14,15 written, b_resp=10.
- w_last asserted on beat 1 of a len=2 burst -> all 3 beats accepted, b_resp=10.
- b_ready held low 5 cycles -> b_valid and b_resp stable; aw_ready=1 one cycle after the handshake. Reset pulsed during W_DATA -> all outputs at reset values, memory zero.
